// File: rtl/riscv_regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// riscv_regfile_mp_pkg
// Shared core definitions for the multi-port integer register file:
//   XLEN            - integer data width of the core
//   NREG_I / NREG_E - implemented register counts for RV32I / RV32E
//   RAW             - register address width (architectural, always 5)
//   reg_addr_t      - register address type
//   addr_live()     - true when an address names a real, writable register
//                     (not x0 and inside the implemented range)
// -----------------------------------------------------------------------------
package riscv_regfile_mp_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG_I = 32;
  localparam int unsigned NREG_E = 16;
  localparam int unsigned RAW    = 5;

  typedef logic [RAW-1:0] reg_addr_t;

  // x0 and addresses beyond the implemented range (RV32E) all collapse onto
  // the same "dead" behaviour: no write, zero read, never busy.
  function automatic logic addr_live(input reg_addr_t a, input int unsigned nreg);
    return (a != '0) && (32'(a) < nreg);
  endfunction

endpackage

// File: rtl/riscv_regfile_sb.sv
// -----------------------------------------------------------------------------
// riscv_regfile_sb
// Per-register pending-write scoreboard for the issue stage.
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_set          - mark i_set_addr as having a pending producer
//   i_set_addr     - register to mark
//   i_clr          - per write port: an enabled write to a live register
//   i_clr_addr     - per write port: address being written (NWR*5)
//   i_rs_addr      - per read port: address being looked up (NRD*5)
//   o_busy         - per read port: registered pending bit of that address
// Busy suppression for same-cycle writes is applied by the parent.
// -----------------------------------------------------------------------------
module riscv_regfile_sb
  import riscv_regfile_mp_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set,
  input  logic [RAW-1:0]       i_set_addr,
  input  logic [NWR-1:0]       i_clr,
  input  logic [NWR*RAW-1:0]   i_clr_addr,
  input  logic [NRD*RAW-1:0]   i_rs_addr,
  output logic [NRD-1:0]       o_busy
);

  localparam int unsigned IW = $clog2(NREG);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (i_clr[k]) begin
        sb_d[i_clr_addr[k*RAW +: IW]] = 1'b0;
      end
    end
    // Applied after the clears so a newly issued producer keeps the bit set.
    if (i_set && addr_live(i_set_addr, NREG)) begin
      sb_d[i_set_addr[IW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_lookup
    reg_addr_t ra;
    assign ra        = i_rs_addr[j*RAW +: RAW];
    assign o_busy[j] = addr_live(ra, NREG) ? sb_q[ra[IW-1:0]] : 1'b0;
  end

endmodule

// File: rtl/riscv_regfile_mp.sv
// -----------------------------------------------------------------------------
// riscv_regfile_mp
// Parametrised multi-port RV32I/RV32E integer register file with optional
// write-to-read bypass and a pending-write scoreboard.
// Ports (port k occupies slice k of each packed vector):
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_regfile_rd_wen    - write enable per write port        (NWR)
//   i_regfile_rd_addr   - write address per write port       (NWR*5)
//   i_regfile_rd_data   - write data per write port          (NWR*XLEN)
//   i_regfile_rs_addr   - read address per read port         (NRD*5)
//   o_regfile_rs_data   - combinational read data            (NRD*XLEN)
//   o_regfile_rs_busy   - addressed register has pending write (NRD)
//   i_sb_set            - mark i_sb_set_addr pending
//   i_sb_set_addr       - register to mark pending
// -----------------------------------------------------------------------------
module riscv_regfile_mp
  import riscv_regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN   = riscv_regfile_mp_pkg::XLEN,
  parameter int unsigned NREG   = NREG_I,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NWR-1:0]        i_regfile_rd_wen,
  input  logic [NWR*RAW-1:0]    i_regfile_rd_addr,
  input  logic [NWR*XLEN-1:0]   i_regfile_rd_data,
  input  logic [NRD*RAW-1:0]    i_regfile_rs_addr,
  output logic [NRD*XLEN-1:0]   o_regfile_rs_data,
  output logic [NRD-1:0]        o_regfile_rs_busy,
  input  logic                  i_sb_set,
  input  logic [RAW-1:0]        i_sb_set_addr
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (!(NREG == NREG_I || NREG == NREG_E)) begin : g_bad_nreg
    $error("riscv_regfile_mp: NREG must be 16 or 32");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("riscv_regfile_mp: NWR must be 1..2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("riscv_regfile_mp: NRD must be 1..4");
  end

  localparam int unsigned IW = $clog2(NREG);

  // ---------------------------------------------------------------------------
  // Write-port unpacking; wr_live folds x0 / out-of-range into the enable
  // ---------------------------------------------------------------------------
  reg_addr_t       wr_addr [NWR];
  logic [XLEN-1:0] wr_data [NWR];
  logic [NWR-1:0]  wr_live;

  for (genvar k = 0; k < NWR; k++) begin : g_wr
    assign wr_addr[k] = i_regfile_rd_addr[k*RAW +: RAW];
    assign wr_data[k] = i_regfile_rd_data[k*XLEN +: XLEN];
    assign wr_live[k] = i_regfile_rd_wen[k] && addr_live(wr_addr[k], NREG);
  end

  // ---------------------------------------------------------------------------
  // Storage and write arbitration (later port overrides earlier)
  // Entry 0 is never written, so it holds its reset value of zero.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wr_live[k]) begin
        regs_d[wr_addr[k][IW-1:0]] = wr_data[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [NRD-1:0] sb_busy;

  riscv_regfile_sb #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (i_sb_set),
    .i_set_addr (i_sb_set_addr),
    .i_clr      (wr_live),
    .i_clr_addr (i_regfile_rd_addr),
    .i_rs_addr  (i_regfile_rs_addr),
    .o_busy     (sb_busy)
  );

  // ---------------------------------------------------------------------------
  // Read ports with optional bypass
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    reg_addr_t       ra;
    logic [XLEN-1:0] rd_data;
    logic            byp_hit;

    assign ra = i_regfile_rs_addr[j*RAW +: RAW];

    always_comb begin
      rd_data = addr_live(ra, NREG) ? regs_q[ra[IW-1:0]] : '0;
      byp_hit = 1'b0;
      if (BYPASS) begin
        // wr_live already excludes x0 and out-of-range, so a dead read
        // address can never pick up bypass data.
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wr_live[k] && (wr_addr[k] == ra)) begin
            rd_data = wr_data[k];
            byp_hit = 1'b1;
          end
        end
      end
    end

    assign o_regfile_rs_data[j*XLEN +: XLEN] = rd_data;
    // A write landing this cycle retires the pending producer.
    assign o_regfile_rs_busy[j]              = sb_busy[j] & ~byp_hit;
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
module tb_riscv_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wen;
  logic [4:0]  wa0, wa1, ra0, ra1, saddr;
  logic [31:0] wd0, wd1;
  logic        sset;

  logic [63:0] rdata1, rdata2;
  logic [1:0]  busy1, busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut1: RV32I, bypass on. dut2: RV32E, bypass off. Both see the same stimulus.
  riscv_regfile_mp #(
    .XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_regfile_rd_wen(wen), .i_regfile_rd_addr({wa1, wa0}),
    .i_regfile_rd_data({wd1, wd0}), .i_regfile_rs_addr({ra1, ra0}),
    .o_regfile_rs_data(rdata1), .o_regfile_rs_busy(busy1),
    .i_sb_set(sset), .i_sb_set_addr(saddr)
  );

  riscv_regfile_mp #(
    .XLEN(32), .NREG(16), .NRD(2), .NWR(2), .BYPASS(1'b0)
  ) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_regfile_rd_wen(wen), .i_regfile_rd_addr({wa1, wa0}),
    .i_regfile_rd_data({wd1, wd0}), .i_regfile_rs_addr({ra1, ra0}),
    .o_regfile_rs_data(rdata2), .o_regfile_rs_busy(busy2),
    .i_sb_set(sset), .i_sb_set_addr(saddr)
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 = dut1 config, index 1 = dut2 config
  // ---------------------------------------------------------------------------
  logic [31:0] mregs [2][32];
  logic        msb   [2][32];

  function automatic int nreg_of(input int c);
    return (c == 0) ? 32 : 16;
  endfunction

  function automatic bit live(input int c, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < nreg_of(c));
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          mregs[c][r] = 32'd0;
          msb[c][r]   = 1'b0;
        end
      end else begin
        if (wen[0] && live(c, wa0)) begin mregs[c][wa0] = wd0; msb[c][wa0] = 1'b0; end
        if (wen[1] && live(c, wa1)) begin mregs[c][wa1] = wd1; msb[c][wa1] = 1'b0; end
        if (sset && live(c, saddr)) msb[c][saddr] = 1'b1;
      end
    end
  end

  function automatic void m_read(input int c, input logic [4:0] a,
                                 output logic [31:0] d, output logic b);
    d = 32'd0;
    b = 1'b0;
    if (live(c, a)) begin
      d = mregs[c][a];
      b = msb[c][a];
      if (c == 0) begin
        if (wen[0] && wa0 == a) begin d = wd0; b = 1'b0; end
        if (wen[1] && wa1 == a) begin d = wd1; b = 1'b0; end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_models(input string tag);
    logic [31:0] d;
    logic        b;
    m_read(0, ra0, d, b); chk({tag, " d1.d0"}, rdata1[31:0],  d); chk({tag, " d1.b0"}, 32'(busy1[0]), 32'(b));
    m_read(0, ra1, d, b); chk({tag, " d1.d1"}, rdata1[63:32], d); chk({tag, " d1.b1"}, 32'(busy1[1]), 32'(b));
    m_read(1, ra0, d, b); chk({tag, " d2.d0"}, rdata2[31:0],  d); chk({tag, " d2.b0"}, 32'(busy2[0]), 32'(b));
    m_read(1, ra1, d, b); chk({tag, " d2.d1"}, rdata2[63:32], d); chk({tag, " d2.b1"}, 32'(busy2[1]), 32'(b));
  endtask

  task automatic idle();
    wen = 2'b00; sset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors for dut1 (hand-computed)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0, ra1;
    logic        set;
    logic [4:0]  sa;
    logic [31:0] e_d0, e_d1;
    logic [1:0]  e_b;
  } vec_t;

  vec_t vt [13];

  initial begin
    vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
    vt[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd5, 5'd6, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
    vt[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 5'd7, 5'd5, 1'b0, 5'd0, 32'h22,       32'hDEADBEEF, 2'b00};
    vt[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd7, 5'd7, 1'b0, 5'd0, 32'h22,       32'h22,       2'b00};
    vt[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd7, 1'b1, 5'd9, 32'h0,        32'h22,       2'b00};
    vt[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        32'h0,        2'b11};
    vt[6]  = '{2'b01, 5'd9, 32'h99,       5'd0, 32'h0,  5'd9, 5'd0, 1'b0, 5'd0, 32'h99,       32'h0,        2'b00};
    vt[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 1'b0, 5'd0, 32'h99,       32'h99,       2'b00};
    vt[8]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'hAB, 5'd9, 5'd9, 1'b1, 5'd9, 32'hAB,       32'hAB,       2'b00};
    vt[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 1'b0, 5'd0, 32'hAB,       32'hAB,       2'b11};
    vt[10] = '{2'b01, 5'd0, 32'hFFFF,     5'd0, 32'h0,  5'd0, 5'd9, 1'b1, 5'd0, 32'h0,        32'hAB,       2'b10};
    vt[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00};
    vt[12] = '{2'b01, 5'd3, 32'hA5A5,     5'd0, 32'h0,  5'd3, 5'd9, 1'b0, 5'd0, 32'hA5A5,     32'hAB,       2'b10};
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    wen = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ra0 = 5'd5; ra1 = 5'd9; sset = 1'b0; saddr = '0;
    @(negedge clk);
    #2;
    chk("rst_hold d0", rdata1[31:0], 32'h0);
    chk("rst_hold busy", 32'(busy1), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-cycle asynchronous reset after a write and a scoreboard set
    wen = 2'b01; wa0 = 5'd5; wd0 = 32'hDEADBEEF; sset = 1'b1; saddr = 5'd6;
    ra0 = 5'd5; ra1 = 5'd6;
    @(negedge clk);
    idle();
    #2;
    chk("pre_rst x5", rdata1[31:0], 32'hDEADBEEF);
    chk("pre_rst busy x6", 32'(busy1[1]), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst x5", rdata1[31:0], 32'h0);
    chk("mid_rst busy", 32'(busy1), 32'h0);
    chk("mid_rst d2 busy", 32'(busy2), 32'h0);
    @(negedge clk);
    // Write during reset: bypass still shows it, the edge drops it
    wen = 2'b01; wa0 = 5'd4; wd0 = 32'h1234; ra0 = 5'd4;
    #2;
    chk("rst_bypass x4", rdata1[31:0], 32'h1234);
    chk("rst_nobyp x4", rdata2[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #2;
    chk("rst_lost x4", rdata1[31:0], 32'h0);
    check_models("post_rst");
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      wen = vt[i].wen; wa0 = vt[i].wa0; wd0 = vt[i].wd0; wa1 = vt[i].wa1; wd1 = vt[i].wd1;
      ra0 = vt[i].ra0; ra1 = vt[i].ra1; sset = vt[i].set; saddr = vt[i].sa;
      #2;
      chk($sformatf("vec%0d d0", i), rdata1[31:0],  vt[i].e_d0);
      chk($sformatf("vec%0d d1", i), rdata1[63:32], vt[i].e_d1);
      chk($sformatf("vec%0d busy", i), 32'(busy1), 32'(vt[i].e_b));
      check_models($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Bypass off vs on: x3 holds A5A5 from the table
    idle();
    wen = 2'b01; wa0 = 5'd3; wd0 = 32'h5A5A; ra0 = 5'd3; ra1 = 5'd3;
    #2;
    chk("byp_on same", rdata1[31:0], 32'h5A5A);
    chk("byp_off same", rdata2[31:0], 32'hA5A5);
    @(negedge clk);
    idle();
    #2;
    chk("byp_on next", rdata1[31:0], 32'h5A5A);
    chk("byp_off next", rdata2[31:0], 32'h5A5A);
    @(negedge clk);

    // Write sweep i -> xi on port 0
    for (int i = 0; i < 32; i++) begin
      wen = 2'b01; wa0 = 5'(i); wd0 = 32'(i);
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      #2;
      chk($sformatf("sweep32 x%0d", i), rdata1[31:0], (i == 0) ? 32'h0 : 32'(i));
      chk($sformatf("sweep32 x%0d", 31 - i), rdata1[63:32], 32'(31 - i));
      chk($sformatf("sweep16 x%0d", i), rdata2[31:0], (i == 0 || i >= 16) ? 32'h0 : 32'(i));
      @(negedge clk);
    end

    // Out-of-range scoreboard set on RV32E
    sset = 1'b1; saddr = 5'd20; ra0 = 5'd20; ra1 = 5'd20;
    @(negedge clk);
    idle();
    #2;
    chk("sb20 d1 busy", 32'(busy1), 32'h3);
    chk("sb20 d2 busy", 32'(busy2), 32'h0);
    chk("sb20 d2 data", rdata2[31:0], 32'h0);
    @(negedge clk);

    // Random traffic against the model
    for (int n = 0; n < 1000; n++) begin
      wen   = 2'($urandom_range(0, 3));
      wa0   = 5'($urandom_range(0, 31));
      wa1   = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      wd0   = $urandom;
      wd1   = $urandom;
      sset  = 1'($urandom_range(0, 1));
      saddr = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra0   = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      ra1   = ($urandom_range(0, 2) == 0) ? saddr : 5'($urandom_range(0, 31));
      #2;
      check_models($sformatf("rand%0d", n));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
